// File: rtl/led_seq_ctrl.sv
// LED sequencer: register-mapped pattern, mode and period, with a prescaled
// step engine that blinks or rotates the pattern on the board LEDs.
//
// state | meaning
// HOLD  | sequencing off; WORK follows PATTERN, prescaler frozen
// COUNT | prescaler counting down toward the next step
// STEP  | one-cycle step: blink/rotate WORK, bump step count, reload
module led_seq_ctrl #(
    parameter logic [23:0] DEFAULT_PERIOD = 24'd5_000_000
) (
    input  logic        led_clk,
    input  logic        ledrst_n,
    input  logic        ledcs,
    input  logic        ledwrite,
    input  logic [1:0]  ledaddr,
    input  logic [31:0] ledwdata,
    output logic [31:0] ledrdata,
    output logic [31:0] ledout
);

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        COUNT = 2'b01,
        STEP  = 2'b10
    } state_t;

    localparam logic [1:0] ADDR_PATTERN = 2'b00;
    localparam logic [1:0] ADDR_MODE    = 2'b01;
    localparam logic [1:0] ADDR_PERIOD  = 2'b10;
    localparam logic [1:0] ADDR_STATUS  = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pattern_q, pattern_d;
    logic [31:0] work_q, work_d;
    logic [2:0]  mode_q, mode_d;
    logic [23:0] period_q, period_d;
    logic [23:0] presc_q, presc_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic        blank_q, blank_d;
    logic [31:0] ledout_q, ledout_d;

    logic        wr_en;
    logic        run_ok;
    logic [23:0] eff_period;
    logic [23:0] reload;

    assign wr_en      = ledcs & ledwrite;
    assign run_ok     = mode_q[2] && (mode_q[1:0] != 2'b00);
    assign eff_period = (period_q == 24'd0) ? 24'd1 : period_q;
    assign reload     = eff_period - 24'd1;

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        work_d     = work_q;
        mode_d     = mode_q;
        period_d   = period_q;
        presc_d    = presc_q;
        step_cnt_d = step_cnt_q;
        blank_d    = blank_q;

        case (state_q)
            HOLD: begin
                work_d = pattern_q;
                if (run_ok) begin
                    state_d = COUNT;
                    presc_d = reload;
                end
            end
            COUNT: begin
                if (!run_ok) begin
                    state_d = HOLD;
                end else if (presc_q == 24'd0) begin
                    state_d = STEP;
                end else begin
                    presc_d = presc_q - 24'd1;
                end
            end
            STEP: begin
                if (!run_ok) begin
                    state_d = HOLD;
                end else begin
                    case (mode_q[1:0])
                        2'b01:   blank_d = ~blank_q;
                        2'b10:   work_d  = {work_q[30:0], work_q[31]};
                        2'b11:   work_d  = {work_q[0], work_q[31:1]};
                        default: ;
                    endcase
                    step_cnt_d = step_cnt_q + 16'd1;
                    presc_d    = reload;
                    state_d    = COUNT;
                end
            end
            default: state_d = HOLD;
        endcase

        // Register writes override whatever the step engine decided this edge.
        if (wr_en) begin
            case (ledaddr)
                ADDR_PATTERN: begin
                    pattern_d  = ledwdata;
                    work_d     = ledwdata;
                    blank_d    = 1'b0;
                    step_cnt_d = step_cnt_q;
                    if (state_d != HOLD) begin
                        presc_d = reload;
                        state_d = COUNT;
                    end
                end
                ADDR_MODE: begin
                    mode_d     = ledwdata[2:0];
                    work_d     = pattern_q;
                    blank_d    = 1'b0;
                    step_cnt_d = 16'd0;
                    presc_d    = presc_q;
                    state_d    = HOLD;
                end
                ADDR_PERIOD: period_d = ledwdata[23:0];
                default: ;
            endcase
        end

        ledout_d = blank_d ? 32'd0 : work_d;
    end

    always_ff @(posedge led_clk or negedge ledrst_n) begin
        if (!ledrst_n) begin
            state_q    <= HOLD;
            pattern_q  <= 32'd0;
            work_q     <= 32'd0;
            mode_q     <= 3'd0;
            period_q   <= DEFAULT_PERIOD;
            presc_q    <= 24'd0;
            step_cnt_q <= 16'd0;
            blank_q    <= 1'b0;
            ledout_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            work_q     <= work_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            presc_q    <= presc_d;
            step_cnt_q <= step_cnt_d;
            blank_q    <= blank_d;
            ledout_q   <= ledout_d;
        end
    end

    always_comb begin
        ledrdata = 32'd0;
        case (ledaddr)
            ADDR_PATTERN: ledrdata = pattern_q;
            ADDR_MODE:    ledrdata = {29'd0, mode_q};
            ADDR_PERIOD:  ledrdata = {8'd0, period_q};
            ADDR_STATUS:  ledrdata = {13'd0, state_q, blank_q, step_cnt_q};
            default:      ledrdata = 32'd0;
        endcase
    end

    assign ledout = ledout_q;

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter DEFAULT_PERIOD, 24'd5_000_000, prescaler reload value loaded at reset.
REQ-002 led_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 ledrst_n  input  1  reset, asynchronous, active-low.
REQ-004 ledcs  input  1  block selected by the address decoder.
REQ-005 ledwrite  input  1  write strobe, active high, qualified by ledcs.
REQ-006 ledaddr  input  2  register select: 00 PATTERN, 01 MODE, 10 PERIOD, 11 STATUS.
REQ-007 ledwdata  input  32  write data from the register file / memorio path.
REQ-008 ledrdata  output  32  read-back data, combinational on ledaddr.
REQ-009 ledout  output  32  registered drive to the board LEDs.

Function
REQ-010 The block SHALL perform a register write when ledcs=1 and ledwrite=1 at a rising edge; otherwise it SHALL perform no write.
REQ-011 PATTERN SHALL be 32 bits, read/write.
REQ-012 MODE SHALL have bits [1:0] sel (00 static, 01 blink, 10 rotate-left, 11 rotate-right) and bit [2] en; bits [31:3] SHALL be ignored on write and read as 0.
REQ-013 PERIOD SHALL be 24 bits; [31:24] SHALL be ignored on write and read as 0.
REQ-014 STATUS SHALL be read-only: [15:0] step count, [16] blank flag, [18:17] FSM state; writes to it SHALL have no effect.
REQ-015 The block SHALL keep an internal 32-bit working register WORK and SHALL drive ledout = blank ? 0 : WORK, registered.
REQ-016 The FSM SHALL have three states: HOLD (00), COUNT (01), STEP (10).
REQ-017 HOLD SHALL be entered whenever en=0 or sel=00; in HOLD the prescaler is frozen and WORK tracks PATTERN.
REQ-018 HOLD->COUNT SHALL occur when en=1 and sel!=00; the prescaler SHALL load eff_period-1, where eff_period = (PERIOD==0) ? 1 : PERIOD.
REQ-019 In COUNT the prescaler SHALL decrement by 1 per cycle; at value 0 the FSM SHALL go to STEP.
REQ-020 STEP SHALL last exactly one cycle and SHALL do the following, then return to COUNT with the prescaler reloaded to eff_period-1.
- blink: toggle blank.
- rotate-left: WORK <= {WORK[30:0],WORK[31]}.
- rotate-right: WORK <= {WORK[0],WORK[31:1]}.
- all modes: step count +1.
REQ-021 Step period SHALL therefore be eff_period+1 cycles.
REQ-022 Step count SHALL wrap 16'hFFFF -> 16'h0000.
REQ-023 A PATTERN write SHALL, on the same edge, set WORK <= ledwdata, clear blank and reload the prescaler; it SHALL take priority over a coincident STEP, whose update is discarded and not counted.
REQ-024 A MODE write SHALL, on the same edge, reload WORK from PATTERN, clear blank, clear step count and force the FSM to HOLD; re-evaluation per REQ-018 SHALL happen on the next edge.
REQ-025 A PERIOD write SHALL NOT disturb a running countdown; the new value SHALL take effect at the next reload.
REQ-026 Write-to-ledout latency SHALL be one edge: ledout reflects the write in the cycle after the writing edge.
REQ-027 ledrdata SHALL return PATTERN, MODE, PERIOD or STATUS per ledaddr regardless of ledcs, and SHALL return current values, not pending ones.

Reset
REQ-028 While ledrst_n=0 the block SHALL asynchronously set ledout=0, PATTERN=0, WORK=0, MODE=0, PERIOD=DEFAULT_PERIOD, prescaler=0, step count=0, blank=0 and FSM=HOLD.
REQ-029 Reset asserted mid-COUNT or in STEP SHALL abort the operation immediately with no partial update; after deassertion the block SHALL start in HOLD.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset then write PATTERN=32'h0000_00F0 -> ledout=32'h0000_00F0 one cycle later; STATUS[18:17]=00.
- PERIOD=3, MODE=3'b110, PATTERN=32'h8000_0001 -> ledout 32'h0000_0003, then 32'h0000_0006, at 4-cycle intervals; step count increments.
- PERIOD=2, MODE=3'b101, PATTERN=32'hFFFF_FFFF -> ledout alternates 0 / 32'hFFFF_FFFF every 3 cycles.
- PERIOD=0, rotate-right, PATTERN=32'h1 -> step every 2 cycles; ledout=32'h8000_0000 after the first step.
- PATTERN write coincident with STEP -> ledout=new data; step count unchanged; next step eff_period+1 cycles later.
- ledrst_n pulsed low mid-COUNT with ledout nonzero -> ledout=0 with no clock edge; PERIOD reads DEFAULT_PERIOD.
